nvdla_m00_axi_ptgen_master: RTL
===============================

Name: nvdla_m00_axi_ptgen_master

Overview:
AXI4 burst traffic-generator master driving the M00_AXI port of the NVDLA BFM wrapper; its AXI slave is the VIP memory agent. On an INIT pulse it writes a deterministic pattern across C_NUM_BURSTS bursts, reads the same region back, compares every beat and reports pass/fail via TXN_DONE/ERROR. Single outstanding transaction, one burst at a time.

Parameters:
C_M_TARGET_SLAVE_BASE_ADDR, 32'h4000_0000, byte base of test region; aligned to C_NUM_BURSTS*C_M_AXI_BURST_LEN*4.
C_M_AXI_BURST_LEN, 16, beats per burst (1..256, power of 2; burst bytes <= 4096).
C_NUM_BURSTS, 4, bursts per phase (power of 2, >=1).
C_M_AXI_ADDR_WIDTH, 32, address width; data width fixed at 32.

Ports:
ACLK  in  1  sole clock, all logic rising-edge.
ARESET  in  1  synchronous, active-high reset.
INIT_AXI_TXN  in  1  start request; rising edge starts a run.
TXN_DONE  out  1  run finished; held high until next accepted start or reset.
ERROR  out  1  sticky fail flag; valid when TXN_DONE=1.
M_AXI_AWADDR  out  ADDR_WIDTH  burst start address.
M_AXI_AWLEN  out  8  C_M_AXI_BURST_LEN-1, constant.
M_AXI_AWVALID  out  1  write address valid.
M_AXI_AWREADY  in  1  write address ready.
M_AXI_WDATA  out  32  write pattern word.
M_AXI_WLAST  out  1  last beat of burst.
M_AXI_WVALID  out  1  write data valid.
M_AXI_WREADY  in  1  write data ready.
M_AXI_BRESP  in  2  write response.
M_AXI_BVALID  in  1  write response valid.
M_AXI_BREADY  out  1  write response ready.
M_AXI_ARADDR  out  ADDR_WIDTH  read burst start address.
M_AXI_ARLEN  out  8  C_M_AXI_BURST_LEN-1, constant.
M_AXI_ARVALID  out  1  read address valid.
M_AXI_ARREADY  in  1  read address ready.
M_AXI_RDATA  in  32  read data.
M_AXI_RRESP  in  2  read response.
M_AXI_RLAST  in  1  last read beat.
M_AXI_RVALID  in  1  read data valid.
M_AXI_RREADY  out  1  read data ready.
(AxSIZE, AxBURST, WSTRB omitted: AXI4 defaults apply, i.e. 4-byte beats, INCR, all strobes set.)

Behaviour:
- Reset: FSM=IDLE; all VALID/READY low, TXN_DONE=0, ERROR=0, counters 0, init edge register 0. Reset mid-run aborts immediately; no response draining required.
- Start: INIT_AXI_TXN sampled into a register; start = in & ~in_q. Accepted only in IDLE or DONE; ignored otherwise. Acceptance clears TXN_DONE, ERROR and all counters. Next cycle FSM=WRITE.
- FSM: IDLE -> WRITE -> READ -> DONE; DONE -> WRITE on next accepted start.
- Burst addressing: burst n (0-based) start = BASE + n*BURST_LEN*4. Pattern word for global beat k (0-based, both phases) = k+1, 32-bit.
- WRITE, per burst: assert AWVALID the cycle after entering the burst; hold AWVALID/AWADDR stable until AWREADY. WVALID asserted only after AW handshake. On WVALID&WREADY advance the beat; a new beat may be presented in the next cycle. WLAST is high exactly on beat BURST_LEN-1. After the last-beat handshake, BREADY=1 until BVALID. BRESP != OKAY sets ERROR. After the final burst's B handshake, FSM=READ.
- READ, per burst: ARVALID is handled like AWVALID. After AR handshake, RREADY=1 continuously until the beat with RLAST is accepted. Each accepted beat compares RDATA to its expected word: a mismatch, RRESP != OKAY, or an RLAST position differing from beat BURST_LEN-1 sets ERROR. After the final burst completes, FSM=DONE.
- DONE: TXN_DONE=1 the cycle after the final R handshake and held; ERROR is stable.
- VALIDs never depend combinationally on READYs. No deadlock if READY is held low; the block simply waits.

Decomposition:
- nvdla_axi_ptgen_pkg: state enum (IDLE/WRITE/READ/DONE), RESP_OKAY=2'b00, localparam beat/burst counter width functions.
- No sub-module is needed. Beat, burst and pattern counters stay inline in the top module.

Test Plan:
- Defaults, VIP slave always ready, INIT pulse at 200ns -> AWADDR 0x4000_0000/0x40/0x80/0xC0, WDATA 1..64, WLAST every 16th beat; reads match; TXN_DONE=1, ERROR=0.
- VIP slave with random backpressure on AWREADY/WREADY/ARREADY/RVALID -> same address/data sequence; VALID/payload stable while stalled; PASS.
- VIP memory corrupts the word at 0x4000_0044 (expected 18) -> ERROR=1 with TXN_DONE=1; the run still completes all 4 read bursts.
- SLVERR returned on the second BRESP -> ERROR=1; the READ phase still executes; TXN_DONE=1.
- ARESET asserted mid-WRITE burst 2 -> next cycle all outputs 0 and FSM=IDLE; a new INIT pulse restarts at 0x4000_0000 with data 1.
- INIT pulsed again during READ -> ignored; INIT after DONE -> TXN_DONE drops and a second full run passes.

Source files
------------

// File: rtl/nvdla_m00_axi_ptgen_master_pkg.sv
// Shared constants for the M00 AXI pattern-generator master: FSM encodings,
// burst sub-phase encodings, AXI response codes and counter sizing helpers.
`timescale 1ns/1ps
package nvdla_axi_ptgen_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Every burst walks ISSUE -> ADDR -> DATA (-> RESP for writes) before the next one starts
  typedef logic [1:0] phase_t;
  localparam phase_t PH_ISSUE = 2'd0;
  localparam phase_t PH_ADDR  = 2'd1;
  localparam phase_t PH_DATA  = 2'd2;
  localparam phase_t PH_RESP  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nvdla_m00_axi_ptgen_master_if.sv
// AXI4 bus carried between the pattern-generator master and its memory slave.
`timescale 1ns/1ps
interface nvdla_m00_axi_ptgen_master_if #(parameter int ADDR_WIDTH = 32);

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arlen, arvalid, input arready,
    input rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awlen, awvalid, output awready,
    input wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/nvdla_m00_axi_ptgen_master.sv
// AXI4 burst traffic generator: writes an incrementing pattern over the test
// region, reads it back, and flags any data, response or RLAST discrepancy.
`timescale 1ns/1ps
module nvdla_m00_axi_ptgen_master
  import nvdla_axi_ptgen_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_AXI_BURST_LEN          = 16,
  parameter int          C_NUM_BURSTS               = 4,
  parameter int          C_M_AXI_ADDR_WIDTH         = 32
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic INIT_AXI_TXN,
  output logic TXN_DONE,
  output logic ERROR,
  nvdla_m00_axi_ptgen_master_if.master m_axi
);

  localparam int BEAT_W      = cnt_width(C_M_AXI_BURST_LEN);
  localparam int BURST_W     = cnt_width(C_NUM_BURSTS);
  localparam int BURST_SHIFT = $clog2(C_M_AXI_BURST_LEN * 4);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(C_M_AXI_BURST_LEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(C_NUM_BURSTS - 1);
  localparam logic [7:0]         AXLEN      = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR =
    C_M_AXI_ADDR_WIDTH'(C_M_TARGET_SLAVE_BASE_ADDR);

  state_t               state;
  phase_t               phase;
  logic                 init_q;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [BURST_W-1:0]   burst_cnt;
  logic [31:0]          pat;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 bready_q;
  logic                 arvalid_q;
  logic                 rready_q;
  logic                 done_q;
  logic                 error_q;

  logic                          start;
  logic                          beat_is_last;
  logic [C_M_AXI_ADDR_WIDTH-1:0] burst_addr;

  assign start        = INIT_AXI_TXN && !init_q && (state == ST_IDLE || state == ST_DONE);
  assign beat_is_last = (beat_cnt == LAST_BEAT);
  assign burst_addr   = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(burst_cnt) << BURST_SHIFT);

  // pat is both the word being written and the word expected back; it restarts at 1 for reads
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      phase     <= PH_ISSUE;
      init_q    <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
      pat       <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (start) begin
        state     <= ST_WRITE;
        phase     <= PH_ISSUE;
        beat_cnt  <= '0;
        burst_cnt <= '0;
        pat       <= 32'd1;
        done_q    <= 1'b0;
        error_q   <= 1'b0;
      end else begin
        case (state)
          ST_WRITE: begin
            case (phase)
              PH_ISSUE: begin
                awvalid_q <= 1'b1;
                phase     <= PH_ADDR;
              end
              PH_ADDR: begin
                if (m_axi.awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  phase     <= PH_DATA;
                end
              end
              PH_DATA: begin
                if (m_axi.wready) begin
                  pat <= pat + 32'd1;
                  if (beat_is_last) begin
                    wvalid_q <= 1'b0;
                    bready_q <= 1'b1;
                    beat_cnt <= '0;
                    phase    <= PH_RESP;
                  end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
                end
              end
              default: begin
                if (m_axi.bvalid) begin
                  bready_q <= 1'b0;
                  phase    <= PH_ISSUE;
                  if (m_axi.bresp != RESP_OKAY) error_q <= 1'b1;
                  if (burst_cnt == LAST_BURST) begin
                    state     <= ST_READ;
                    burst_cnt <= '0;
                    pat       <= 32'd1;
                  end else begin
                    burst_cnt <= burst_cnt + BURST_W'(1);
                  end
                end
              end
            endcase
          end
          ST_READ: begin
            case (phase)
              PH_ISSUE: begin
                arvalid_q <= 1'b1;
                phase     <= PH_ADDR;
              end
              PH_ADDR: begin
                if (m_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  phase     <= PH_DATA;
                end
              end
              PH_DATA: begin
                if (m_axi.rvalid) begin
                  pat <= pat + 32'd1;
                  if (m_axi.rdata != pat || m_axi.rresp != RESP_OKAY ||
                      m_axi.rlast != beat_is_last)
                    error_q <= 1'b1;
                  if (m_axi.rlast) begin
                    rready_q <= 1'b0;
                    beat_cnt <= '0;
                    phase    <= PH_ISSUE;
                    if (burst_cnt == LAST_BURST) begin
                      state     <= ST_DONE;
                      done_q    <= 1'b1;
                      burst_cnt <= '0;
                    end else begin
                      burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                  end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign m_axi.awaddr  = burst_addr;
  assign m_axi.awlen   = AXLEN;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = pat;
  assign m_axi.wlast   = wvalid_q && beat_is_last;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = burst_addr;
  assign m_axi.arlen   = AXLEN;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign TXN_DONE      = done_q;
  assign ERROR         = error_q;

endmodule
